// File: rtl/serial_rx.sv
// serial_rx: oversampling async-serial receiver with parity/framing/overrun flags and valid/ready output
module serial_rx #(
  parameter int DATA_BITS    = 7,
  parameter int PARITY       = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  input  logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF > 0 ? HALF - 1 : 0);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PAR_BIT, STOP} state_t;
  state_t state;
  logic [1:0] sync;
  logic [1:0] sync_ok;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  logic par;
  logic fe_acc;
  logic s;
  logic tick;
  assign s = sync[1];
  assign tick = cnt == '0;
  // Two-flop line synchroniser; sync_ok marks when s reflects the real line rather than reset values
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= 2'b11;
      sync_ok <= 2'b00;
    end else begin
      sync <= {sync[0], serial_in};
      sync_ok <= {sync_ok[0], 1'b1};
    end
  end
  // Frame FSM: counts down to each mid-bit sample point, assembles the word and drives the handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= WAIT_IDLE;
      cnt <= '0;
      bcnt <= '0;
      sh <= '0;
      par <= 1'b0;
      fe_acc <= 1'b0;
      data_out <= '0;
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      busy <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready_in) valid <= 1'b0;
      case (state)
        WAIT_IDLE: if (s && sync_ok[1]) state <= IDLE;
        IDLE: if (!s) begin
          par <= 1'b0;
          fe_acc <= 1'b0;
          bcnt <= '0;
          busy <= 1'b1;
          state <= HALF == 0 ? DATA : START;
          cnt <= HALF == 0 ? C_BIT : C_HALF;
        end
        START: if (!tick) cnt <= cnt - 1'b1;
        else if (s) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          state <= DATA;
          cnt <= C_BIT;
        end
        DATA: if (!tick) cnt <= cnt - 1'b1;
        else begin
          cnt <= C_BIT;
          sh <= DATA_BITS'({s, sh} >> 1);
          par <= par ^ s;
          bcnt <= bcnt == B_LAST ? '0 : bcnt + 1'b1;
          if (bcnt == B_LAST) state <= PARITY != 0 ? PAR_BIT : STOP;
        end
        PAR_BIT: if (!tick) cnt <= cnt - 1'b1;
        else begin
          cnt <= C_BIT;
          par <= par ^ s;
          state <= STOP;
        end
        STOP: if (!tick) cnt <= cnt - 1'b1;
        else begin
          cnt <= C_BIT;
          bcnt <= bcnt + 1'b1;
          fe_acc <= fe_acc | ~s;
          if (bcnt == S_LAST) begin
            state <= s ? IDLE : WAIT_IDLE;
            busy <= 1'b0;
            data_out <= sh;
            parity_err <= PARITY == 0 ? 1'b0 : PARITY == 1 ? par : ~par;
            frame_err <= fe_acc | ~s;
            valid <= 1'b1;
            overrun <= valid && !ready_in;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end
endmodule
